// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle EX-stage ALU.
//   Request : valid_i, ready_o, data1_i, data2_i, ALUCtrl_i
//   Response: valid_o, ready_i, data_o, Zero_o, Neg_o, err_o
// Modports: master = pipeline side (drives requests, consumes results),
//           slave  = ALU side.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [2:0]       ALUCtrl_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             Zero_o;
    logic             Neg_o;
    logic             err_o;

    modport master (
        output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        input  ready_o, valid_o, data_o, Zero_o, Neg_o, err_o
    );

    modport slave (
        input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        output ready_o, valid_o, data_o, Zero_o, Neg_o, err_o
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU with registered result and valid/ready
// handshake on both sides. ADD/SUB/SLL/SRA/XOR/AND finish in one cycle at
// full throughput; MUL uses a radix-2 shift-add engine (WIDTH iterations).
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - alu_mc_if.slave (request operands/opcode, result and flags)
//
// Build option: define ALU_MC_MUL_EN to build the MUL state and engine.
// Without it opcode 011 is reported as illegal (data_o=0, Zero_o=1, err_o=1).
//
// state | meaning
// IDLE  | no result held, ready for a request
// MUL   | shift-add iterations in progress, ready_o low
// DONE  | result presented on data_o with valid_o high
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_AND = 3'b111;
`ifdef ALU_MC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b011;
`endif

`ifdef ALU_MC_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [SHW-1:0]   shamt;

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

    // A finished result can be replaced in the same cycle it is consumed.
    assign bus.ready_o = (state == IDLE) || ((state == DONE) && bus.ready_i);
    assign accept      = bus.valid_i && bus.ready_o;
    assign shamt       = bus.data2_i[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (bus.ALUCtrl_i)
            OP_ADD:  alu_res = bus.data1_i + bus.data2_i;
            OP_SLL:  alu_res = bus.data1_i << shamt;
            OP_SUB:  alu_res = bus.data1_i - bus.data2_i;
            OP_XOR:  alu_res = bus.data1_i ^ bus.data2_i;
            OP_SRA:  alu_res = $unsigned($signed(bus.data1_i) >>> shamt);
            OP_AND:  alu_res = bus.data1_i & bus.data2_i;
`ifdef ALU_MC_MUL_EN
            OP_MUL:  alu_res = '0;  // handled by the iterative engine
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            bus.valid_o <= 1'b0;
            bus.data_o  <= '0;
            bus.Zero_o  <= 1'b0;
            bus.Neg_o   <= 1'b0;
            bus.err_o   <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef ALU_MC_MUL_EN
                        if (bus.ALUCtrl_i == OP_MUL) begin
                            state       <= MUL;
                            bus.valid_o <= 1'b0;
                            mcand       <= bus.data1_i;
                            mplier      <= bus.data2_i;
                            acc         <= '0;
                            cnt         <= SHW'(WIDTH - 1);
                        end else begin
`endif
                            state       <= DONE;
                            bus.valid_o <= 1'b1;
                            bus.data_o  <= alu_res;
                            bus.Zero_o  <= (alu_res == '0);
                            bus.Neg_o   <= alu_res[WIDTH-1];
                            bus.err_o   <= alu_err;
`ifdef ALU_MC_MUL_EN
                        end
`endif
                    end else if ((state == DONE) && bus.ready_i) begin
                        state       <= IDLE;
                        bus.valid_o <= 1'b0;
                    end
                end
`ifdef ALU_MC_MUL_EN
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    // Counter at 0 means this edge performs the last iteration.
                    if (cnt == '0) begin
                        state       <= DONE;
                        bus.valid_o <= 1'b1;
                        bus.data_o  <= acc_next;
                        bus.Zero_o  <= (acc_next == '0);
                        bus.Neg_o   <= acc_next[WIDTH-1];
                        bus.err_o   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_mc;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] exp, input logic exp_err);
        chk({tag, " valid"}, {31'd0, bus.valid_o}, 32'd1);
        chk({tag, " data"},  bus.data_o, exp);
        chk({tag, " zero"},  {31'd0, bus.Zero_o}, {31'd0, (exp == 32'd0)});
        chk({tag, " neg"},   {31'd0, bus.Neg_o},  {31'd0, exp[31]});
        chk({tag, " err"},   {31'd0, bus.err_o},  {31'd0, exp_err});
    endtask

    logic [2:0]  t_op  [6];
    logic [31:0] t_a   [6];
    logic [31:0] t_b   [6];
    logic [31:0] t_exp [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.valid_i   = 1'b0;
        bus.ALUCtrl_i = 3'b000;
        bus.data1_i   = '0;
        bus.data2_i   = '0;
        bus.ready_i   = 1'b1;

        t_op[0] = 3'b001; t_a[0] = 32'h0000_0001; t_b[0] = 32'h0000_0021; t_exp[0] = 32'h0000_0002;
        t_op[1] = 3'b001; t_a[1] = 32'h8000_0001; t_b[1] = 32'h0000_001F; t_exp[1] = 32'h8000_0000;
        t_op[2] = 3'b111; t_a[2] = 32'hF0F0_F0F0; t_b[2] = 32'hFF00_FF00; t_exp[2] = 32'hF000_F000;
        t_op[3] = 3'b010; t_a[3] = 32'h0000_0003; t_b[3] = 32'h0000_0005; t_exp[3] = 32'hFFFF_FFFE;
        t_op[4] = 3'b101; t_a[4] = 32'h4000_0000; t_b[4] = 32'h0000_0003; t_exp[4] = 32'h0800_0000;
        t_op[5] = 3'b000; t_a[5] = 32'hFFFF_FFFF; t_b[5] = 32'h0000_0001; t_exp[5] = 32'h0000_0000;

        // Reset state, with a request offered that must be ignored.
        @(negedge clk);
        drive(3'b000, 32'd1, 32'd1);
        @(negedge clk);
        chk("rst valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst data",  bus.data_o, 32'd0);
        chk("rst zero",  {31'd0, bus.Zero_o}, 32'd0);
        chk("rst neg",   {31'd0, bus.Neg_o}, 32'd0);
        chk("rst err",   {31'd0, bus.err_o}, 32'd0);
        chk("rst ready", {31'd0, bus.ready_o}, 32'd1);
        bus.valid_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst valid", {31'd0, bus.valid_o}, 32'd0);

        // ADD overflow into sign bit.
        drive(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk_res("add", 32'h8000_0000, 1'b0);
        @(negedge clk);
        chk("add drop", {31'd0, bus.valid_o}, 32'd0);

        // Back-to-back SUB then SRA.
        drive(3'b010, 32'd5, 32'd5);
        @(negedge clk);
        chk_res("sub", 32'd0, 1'b0);
        chk("sub ready", {31'd0, bus.ready_o}, 32'd1);
        drive(3'b101, 32'h8000_0000, 32'h0000_0024);
        @(negedge clk);
        chk_res("sra", 32'hF800_0000, 1'b0);
        chk("sra ready", {31'd0, bus.ready_o}, 32'd1);

        // Streamed table of single-cycle ops.
        for (int i = 0; i < 6; i++) begin
            drive(t_op[i], t_a[i], t_b[i]);
            @(negedge clk);
            chk_res($sformatf("tbl%0d", i), t_exp[i], 1'b0);
        end
        bus.valid_i = 1'b0;
        @(negedge clk);

        // Backpressure: result held, new request refused.
        bus.ready_i = 1'b0;
        drive(3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000);
        @(negedge clk);
        drive(3'b000, 32'd9, 32'd9);
        for (int i = 0; i < 5; i++) begin
            chk_res($sformatf("bp%0d", i), 32'h0F0F_F0F0, 1'b0);
            chk($sformatf("bp%0d ready", i), {31'd0, bus.ready_o}, 32'd0);
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        #1;
        chk("bp release ready", {31'd0, bus.ready_o}, 32'd1);
        @(negedge clk);
        chk("bp drop", {31'd0, bus.valid_o}, 32'd0);

        // Illegal opcode, then a legal op clears err.
        drive(3'b110, 32'd5, 32'd3);
        @(negedge clk);
        chk_res("ill110", 32'd0, 1'b1);
        drive(3'b000, 32'd1, 32'd2);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk_res("after ill", 32'd3, 1'b0);
        @(negedge clk);

`ifdef ALU_MC_MUL_EN
        // MUL latency and result.
        drive(3'b011, 32'hFFFF_FFFF, 32'd3);
        @(negedge clk);
        bus.valid_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("mul busy%0d", i), {30'd0, bus.ready_o, bus.valid_o}, 32'd0);
            @(negedge clk);
        end
        chk_res("mul", 32'hFFFF_FFFD, 1'b0);
        drive(3'b011, 32'h1234_5678, 32'h0000_0010);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (32) @(negedge clk);
        chk_res("mul2", 32'h2345_6780, 1'b0);
        drive(3'b011, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (32) @(negedge clk);
        chk_res("mul3", 32'h0000_0006, 1'b0);
        @(negedge clk);

        // Reset 10 cycles into a MUL.
        drive(3'b011, 32'd7, 32'd6);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (10) @(negedge clk);
`else
        // MUL compiled out: opcode 011 is illegal.
        drive(3'b011, 32'd7, 32'd3);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk_res("mul off", 32'd0, 1'b1);
        @(negedge clk);

        // Reset while a result is held under backpressure.
        bus.ready_i = 1'b0;
        drive(3'b000, 32'h8000_0000, 32'd5);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk_res("pre-rst hold", 32'h8000_0005, 1'b0);
`endif
        rst = 1'b1;
        #1;
        chk("mid-rst valid", {31'd0, bus.valid_o}, 32'd0);
        chk("mid-rst data",  bus.data_o, 32'd0);
        chk("mid-rst flags", {29'd0, bus.Zero_o, bus.Neg_o, bus.err_o}, 32'd0);
        chk("mid-rst ready", {31'd0, bus.ready_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_o !== 1'b0)
                chk($sformatf("stale valid %0d", i), {31'd0, bus.valid_o}, 32'd0);
        end
        chk("no stale valid", {31'd0, bus.valid_o}, 32'd0);
        drive(3'b000, 32'd2, 32'd2);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk_res("add after rst", 32'd4, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
